inv_butterfly_unit: RTL and testbench

- Radix-2 inverse (decimation-in-frequency) butterfly, the reverse of the forward butterflyUnit.
- Given forward outputs p and q and the twiddle w, computes a = (p+q)/2 and b = ((p-q)/2)*conj(w).
- Sits on the inverse-FFT path.
- Time-shares one signed HxH multiplier over four cycles, with a valid/ready handshake on each side.

---
 rtl/inv_bfly_pkg.sv | 42 ++++
 rtl/cplx_serial_mac.sv | 56 +++++
 rtl/inv_butterfly_unit.sv | 139 +++++++++++++
 tb/tb_inv_butterfly_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_bfly_pkg.sv
// rtl/inv_bfly_pkg.sv - shared states, saturation and complex pack/unpack helpers
package inv_bfly_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    FIN,
    HOLD
  } state_t;

  function automatic logic [63:0] lo_mask(input int h);
    return (64'd1 << h) - 64'd1;
  endfunction

  // Packed complex words carry the real half above the imaginary half.
  function automatic logic [63:0] cplx_re(input logic [63:0] x, input int h);
    return (x >> h) & lo_mask(h);
  endfunction

  function automatic logic [63:0] cplx_im(input logic [63:0] x, input int h);
    return x & lo_mask(h);
  endfunction

  function automatic logic [63:0] cplx_pack(input logic [63:0] re, input logic [63:0] im,
                                            input int h);
    return ((re & lo_mask(h)) << h) | (im & lo_mask(h));
  endfunction

  function automatic logic signed [63:0] sat_h(input logic signed [63:0] x, input int h);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (h - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cplx_serial_mac.sv
// rtl/cplx_serial_mac.sv - one shared signed multiplier feeding real/imag accumulators
module cplx_serial_mac #(
  parameter int H = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [1:0]         sel,
  input  logic [H-1:0]       d_re,
  input  logic [H-1:0]       d_im,
  input  logic [H-1:0]       w_re,
  input  logic [H-1:0]       w_im,
  output logic [2*H+1:0]     acc_re,
  output logic [2*H+1:0]     acc_im
);

  localparam int ACC_W = 2 * H + 2;

  logic [H-1:0]          op_a;
  logic [H-1:0]          op_b;
  logic signed [2*H-1:0] prod;
  logic [ACC_W-1:0]      prod_ext;

  // sel 0..3: d_re*w_re, d_im*w_im, d_im*w_re, d_re*w_im
  always_comb begin
    op_a = d_re;
    op_b = w_re;
    case (sel)
      2'd0: begin op_a = d_re; op_b = w_re; end
      2'd1: begin op_a = d_im; op_b = w_im; end
      2'd2: begin op_a = d_im; op_b = w_re; end
      default: begin op_a = d_re; op_b = w_im; end
    endcase
  end

  assign prod     = $signed(op_a) * $signed(op_b);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      case (sel)
        2'd0, 2'd1: acc_re <= acc_re + prod_ext;
        2'd2:       acc_im <= acc_im + prod_ext;
        default:    acc_im <= acc_im - prod_ext;
      endcase
    end
  end

endmodule

// File: rtl/inv_butterfly_unit.sv
// rtl/inv_butterfly_unit.sv - radix-2 inverse butterfly a=(p+q)/2, b=((p-q)/2)*conj(w)
// Optional build macro INV_BFLY_ROUND_EN selects round-half-up on the b result.
module inv_butterfly_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] twiddle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  import inv_bfly_pkg::*;

  localparam int H     = WIDTH / 2;
  localparam int ACC_W = 2 * H + 2;

`ifdef INV_BFLY_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'd1 << (H - 2));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  state_t state, state_next;

  logic         load;
  logic         mac_en;
  logic [1:0]   mac_sel;
  logic         fin;
  logic         done;

  logic [H-1:0] p_re, p_im, q_re, q_im, tw_re, tw_im;
  logic [H:0]   sum_re, sum_im, dif_re, dif_im;
  logic [H-1:0] s_re, s_im, d_re, d_im, w_re, w_im;

  logic [ACC_W-1:0]        acc_re, acc_im;
  logic signed [ACC_W-1:0] sh_re, sh_im;
  logic [H-1:0]            b_re, b_im;

  assign p_re  = H'(cplx_re(64'(p), H));
  assign p_im  = H'(cplx_im(64'(p), H));
  assign q_re  = H'(cplx_re(64'(q), H));
  assign q_im  = H'(cplx_im(64'(q), H));
  assign tw_re = H'(cplx_re(64'(twiddle), H));
  assign tw_im = H'(cplx_im(64'(twiddle), H));

  // One extra bit keeps the sum exact; halving the H+1-bit value always fits in H bits.
  assign sum_re = {p_re[H-1], p_re} + {q_re[H-1], q_re};
  assign sum_im = {p_im[H-1], p_im} + {q_im[H-1], q_im};
  assign dif_re = {p_re[H-1], p_re} - {q_re[H-1], q_re};
  assign dif_im = {p_im[H-1], p_im} - {q_im[H-1], q_im};

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    mac_en     = 1'b0;
    mac_sel    = 2'd0;
    fin        = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        load       = 1'b1;
        state_next = MUL0;
      end
      MUL0: begin mac_en = 1'b1; mac_sel = 2'd0; state_next = MUL1; end
      MUL1: begin mac_en = 1'b1; mac_sel = 2'd1; state_next = MUL2; end
      MUL2: begin mac_en = 1'b1; mac_sel = 2'd2; state_next = MUL3; end
      MUL3: begin mac_en = 1'b1; mac_sel = 2'd3; state_next = FIN;  end
      FIN:  begin fin = 1'b1; state_next = HOLD; end
      HOLD: if (out_ready) begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_re <= '0; s_im <= '0;
      d_re <= '0; d_im <= '0;
      w_re <= '0; w_im <= '0;
    end else if (load) begin
      s_re <= H'(sum_re >> 1);
      s_im <= H'(sum_im >> 1);
      d_re <= H'(dif_re >> 1);
      d_im <= H'(dif_im >> 1);
      w_re <= tw_re;
      w_im <= tw_im;
    end
  end

  cplx_serial_mac #(.H(H)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .en     (mac_en),
    .sel    (mac_sel),
    .d_re   (d_re),
    .d_im   (d_im),
    .w_re   (w_re),
    .w_im   (w_im),
    .acc_re (acc_re),
    .acc_im (acc_im)
  );

  assign sh_re = ($signed(acc_re) + RND) >>> (H - 1);
  assign sh_im = ($signed(acc_im) + RND) >>> (H - 1);
  assign b_re  = H'(sat_h(64'(sh_re), H));
  assign b_im  = H'(sat_h(64'(sh_im), H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (fin) begin
      out_valid <= 1'b1;
      out_a     <= WIDTH'(cplx_pack(64'(s_re), 64'(s_im), H));
      out_b     <= WIDTH'(cplx_pack(64'(b_re), 64'(b_im), H));
    end else if (done) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_butterfly_unit.sv
// tb/tb_inv_butterfly_unit.sv - self-checking bench for inv_butterfly_unit (WIDTH=16)
module tb_inv_butterfly_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p;
  logic [15:0] q;
  logic [15:0] twiddle;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef INV_BFLY_ROUND_EN
  localparam int RND = 64;
  localparam logic [15:0] RND_VEC_B = 16'h0100;
`else
  localparam int RND = 0;
  localparam logic [15:0] RND_VEC_B = 16'h0000;
`endif

  typedef struct {
    logic [15:0] p;
    logic [15:0] q;
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  vec_t vecs[4];

  inv_butterfly_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .q         (q),
    .twiddle   (twiddle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference: exact integer complex arithmetic, floor division, clamp.
  function automatic void model(input logic [15:0] tp, input logic [15:0] tq,
                                input logic [15:0] tw,
                                output logic [15:0] ea, output logic [15:0] eb);
    int pr, pi, qr, qi, wr, wi, sr, si, dr, di, ar, ai, br, bi;
    pr = sx8(tp[15:8]); pi = sx8(tp[7:0]);
    qr = sx8(tq[15:8]); qi = sx8(tq[7:0]);
    wr = sx8(tw[15:8]); wi = sx8(tw[7:0]);
    sr = fdiv(pr + qr, 2); si = fdiv(pi + qi, 2);
    dr = fdiv(pr - qr, 2); di = fdiv(pi - qi, 2);
    ar = dr * wr + di * wi;
    ai = di * wr - dr * wi;
    br = clamp8(fdiv(ar + RND, 128));
    bi = clamp8(fdiv(ai + RND, 128));
    ea = {8'(sr), 8'(si)};
    eb = {8'(br), 8'(bi)};
  endfunction

  task automatic start_txn(input logic [15:0] tp, input logic [15:0] tq, input logic [15:0] tw);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_before_start", 32'(in_ready), 32'd1);
    p = tp; q = tq; twiddle = tw;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    p = 16'($urandom); q = 16'($urandom); twiddle = 16'($urandom);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out(input logic [15:0] ea);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_after_drop", 32'(in_ready), 32'd1);
    check("a_retained", 32'(out_a), 32'(ea));
  endtask

  task automatic run_txn(input logic [15:0] tp, input logic [15:0] tq, input logic [15:0] tw,
                         input logic [15:0] ea, input logic [15:0] eb, input int hold);
    int lat;
    start_txn(tp, tq, tw);
    wait_valid(lat);
    check("latency", 32'(lat), 32'd5);
    check("out_a", 32'(out_a), 32'(ea));
    check("out_b", 32'(out_b), 32'(eb));
    repeat (hold) @(negedge clk);
    if (hold > 0) check("b_held", 32'(out_b), 32'(eb));
    release_out(ea);
  endtask

  initial begin
    logic [15:0] ea, eb, ea2, eb2;
    int lat;

    vecs[0] = '{p: 16'h0300, q: 16'h0700, w: 16'h7F00, a: 16'h0500, b: 16'hFE00};
    vecs[1] = '{p: 16'h0A04, q: 16'h0200, w: 16'h0080, a: 16'h0602, b: 16'hFE04};
    vecs[2] = '{p: 16'h8000, q: 16'h7F00, w: 16'h8000, a: 16'hFF00, b: 16'h7F00};
    vecs[3] = '{p: 16'h0200, q: 16'h0000, w: 16'h4000, a: 16'h0100, b: RND_VEC_B};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p = '0; q = '0; twiddle = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_txn(vecs[i].p, vecs[i].q, vecs[i].w, vecs[i].a, vecs[i].b, i);

    // Backpressure: result held, new request refused until one out_ready cycle.
    model(16'h1E3C, 16'hF20A, 16'h5AA6, ea, eb);
    model(16'h4010, 16'h2030, 16'h7F00, ea2, eb2);
    start_txn(16'h1E3C, 16'hF20A, 16'h5AA6);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd5);
    p = 16'h4010; q = 16'h2030; twiddle = 16'h7F00;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_a_stable", 32'(out_a), 32'(ea));
      check("bp_b_stable", 32'(out_b), 32'(eb));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_ready_next", 32'(in_ready), 32'd1);
    @(posedge clk);
    wait_valid(lat);
    check("bp2_latency", 32'(lat), 32'd5);
    check("bp2_out_a", 32'(out_a), 32'(ea2));
    check("bp2_out_b", 32'(out_b), 32'(eb2));
    release_out(ea2);

    // Reset in MUL2 abandons the transaction.
    start_txn(16'h1234, 16'h0567, 16'h7F00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_a", 32'(out_a), 32'd0);
    check("midrst_b", 32'(out_b), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_valid", 32'(out_valid), 32'd0);
    run_txn(vecs[0].p, vecs[0].q, vecs[0].w, vecs[0].a, vecs[0].b, 0);

    for (int r = 0; r < 40; r++) begin
      logic [15:0] rp, rq, rw;
      rp = 16'($urandom); rq = 16'($urandom); rw = 16'($urandom);
      model(rp, rq, rw, ea, eb);
      run_txn(rp, rq, rw, ea, eb, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
